// File: rtl/atax_pkg.sv
// -----------------------------------------------------------------------------
// atax_pkg
// Shared definitions for the ATAX kernel (y = A^T * (A * x)).
//   - default matrix dimension and data width
//   - FSM state encoding, as typed localparam constants
//   - addr_w(): address width for a memory of a given depth (never below 1)
// -----------------------------------------------------------------------------
package atax_pkg;

  localparam int N_DEFAULT      = 8;
  localparam int DATA_W_DEFAULT = 32;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLR    = 3'd1;
  localparam state_t S_DOT_RD = 3'd2;
  localparam state_t S_DOT_AC = 3'd3;
  localparam state_t S_UPD_RD = 3'd4;
  localparam state_t S_UPD_WR = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  // A one-word memory still needs a one-bit address bus.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/atax_mac.sv
// -----------------------------------------------------------------------------
// atax_mac
// Combinational signed multiply-add: y = a + b * c, kept to the low DATA_W
// bits so that both the product and the sum wrap (two's complement).
// Ports:
//   a, b, c : DATA_W-bit signed operands
//   y       : DATA_W-bit signed result
// -----------------------------------------------------------------------------
module atax_mac
  import atax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] prod;

  // The low DATA_W bits of a product are the same for signed and unsigned
  // operands, so a DATA_W-wide multiply gives exactly the wrapped result.
  assign prod = b * c;
  assign y    = a + prod;

endmodule

// File: rtl/kernel_atax.sv
// -----------------------------------------------------------------------------
// kernel_atax
// Start/finish accelerator computing y = A^T * (A * x) over an N x N matrix of
// signed DATA_W-bit words held in external dual-port RAMs.
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   start                 : level-sampled in IDLE, begins a run
//   finish                : one-cycle completion pulse
//   main_y_*              : y RAM (N words). Port a clears and reads,
//                           port b writes the updated words.
//   main_x_*              : x RAM (N words). Port a reads, port b unused.
//   main_A_a0_a0_*        : A RAM (N*N words, row-major). Port a reads,
//                           port b unused.
//   *_out_{a,b}           : RAM read data, valid one cycle after enable.
//   *_byteena_{a,b}       : always all-ones.
// -----------------------------------------------------------------------------
module kernel_atax
  import atax_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       finish,

  output logic                       main_y_write_enable_a,
  output logic                       main_y_enable_a,
  output logic [addr_w(N)-1:0]       main_y_address_a,
  output logic [DATA_W-1:0]          main_y_in_a,
  output logic [DATA_W/8-1:0]        main_y_byteena_a,
  input  logic [DATA_W-1:0]          main_y_out_a,
  output logic                       main_y_write_enable_b,
  output logic                       main_y_enable_b,
  output logic [addr_w(N)-1:0]       main_y_address_b,
  output logic [DATA_W-1:0]          main_y_in_b,
  output logic [DATA_W/8-1:0]        main_y_byteena_b,
  input  logic [DATA_W-1:0]          main_y_out_b,

  output logic                       main_x_write_enable_a,
  output logic                       main_x_enable_a,
  output logic [addr_w(N)-1:0]       main_x_address_a,
  output logic [DATA_W-1:0]          main_x_in_a,
  output logic [DATA_W/8-1:0]        main_x_byteena_a,
  input  logic [DATA_W-1:0]          main_x_out_a,
  output logic                       main_x_write_enable_b,
  output logic                       main_x_enable_b,
  output logic [addr_w(N)-1:0]       main_x_address_b,
  output logic [DATA_W-1:0]          main_x_in_b,
  output logic [DATA_W/8-1:0]        main_x_byteena_b,
  input  logic [DATA_W-1:0]          main_x_out_b,

  output logic                       main_A_a0_a0_write_enable_a,
  output logic                       main_A_a0_a0_enable_a,
  output logic [addr_w(N*N)-1:0]     main_A_a0_a0_address_a,
  output logic [DATA_W-1:0]          main_A_a0_a0_in_a,
  output logic [DATA_W/8-1:0]        main_A_a0_a0_byteena_a,
  input  logic [DATA_W-1:0]          main_A_a0_a0_out_a,
  output logic                       main_A_a0_a0_write_enable_b,
  output logic                       main_A_a0_a0_enable_b,
  output logic [addr_w(N*N)-1:0]     main_A_a0_a0_address_b,
  output logic [DATA_W-1:0]          main_A_a0_a0_in_b,
  output logic [DATA_W/8-1:0]        main_A_a0_a0_byteena_b,
  input  logic [DATA_W-1:0]          main_A_a0_a0_out_b
);

  localparam int CW = addr_w(N);      // i / j counter and x / y address width
  localparam int AW = addr_w(N * N);  // A address width
  localparam int BW = DATA_W / 8;

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic [CW-1:0]      i_reg, i_next;
  logic [CW-1:0]      j_reg, j_next;      // also the clear index k in CLR
  logic [DATA_W-1:0]  tmp_reg, tmp_next;
  logic               finish_reg;

  logic [AW-1:0]      a_addr;
  logic [DATA_W-1:0]  mac_a, mac_b, mac_c, mac_y;

  // Port b read data is never requested; fold it into one ignored signal.
  logic unused_inputs;
  assign unused_inputs = ^{main_y_out_b, main_x_out_b, main_A_a0_a0_out_b};

  // ---------------------------------------------------------------------------
  // Shared multiply-add
  //   DOT_AC : tmp + A[i][j] * x[j]
  //   UPD_WR : y[j] + A[i][j] * tmp
  // ---------------------------------------------------------------------------
  assign mac_a = (state_reg == S_UPD_WR) ? main_y_out_a : tmp_reg;
  assign mac_b = main_A_a0_a0_out_a;
  assign mac_c = (state_reg == S_UPD_WR) ? tmp_reg : main_x_out_a;

  atax_mac #(
    .DATA_W (DATA_W)
  ) u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (mac_c),
    .y (mac_y)
  );

  // Row-major address; written as multiply-add so non-power-of-two N works.
  assign a_addr = AW'(i_reg) * AW'(N) + AW'(j_reg);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    tmp_next   = tmp_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CLR;
          i_next     = '0;
          j_next     = '0;
        end
      end

      S_CLR: begin
        if (j_reg == LAST) begin
          j_next     = '0;
          tmp_next   = '0;
          state_next = S_DOT_RD;
        end else begin
          j_next = j_reg + ONE;
        end
      end

      S_DOT_RD: begin
        state_next = S_DOT_AC;
      end

      S_DOT_AC: begin
        tmp_next = mac_y;
        if (j_reg == LAST) begin
          j_next     = '0;
          state_next = S_UPD_RD;
        end else begin
          j_next     = j_reg + ONE;
          state_next = S_DOT_RD;
        end
      end

      S_UPD_RD: begin
        state_next = S_UPD_WR;
      end

      S_UPD_WR: begin
        if (j_reg == LAST) begin
          j_next = '0;
          if (i_reg == LAST) begin
            state_next = S_DONE;
          end else begin
            i_next     = i_reg + ONE;
            tmp_next   = '0;
            state_next = S_DOT_RD;
          end
        end else begin
          j_next     = j_reg + ONE;
          state_next = S_UPD_RD;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. finish is registered off DONE, so it rises the cycle after the
  // FSM leaves DONE and a held start relaunches from IDLE one edge later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      i_reg      <= '0;
      j_reg      <= '0;
      tmp_reg    <= '0;
      finish_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      i_reg      <= i_next;
      j_reg      <= j_next;
      tmp_reg    <= tmp_next;
      finish_reg <= (state_reg == S_DONE);
    end
  end

  assign finish = finish_reg;

  // ---------------------------------------------------------------------------
  // RAM port drive. Addresses and data are forced to zero whenever the port is
  // not enabled so idle ports present a quiet bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_y_write_enable_a       = 1'b0;
    main_y_enable_a             = 1'b0;
    main_y_address_a            = '0;
    main_y_in_a                 = '0;   // CLR writes zeros
    main_y_write_enable_b       = 1'b0;
    main_y_enable_b             = 1'b0;
    main_y_address_b            = '0;
    main_y_in_b                 = '0;

    main_x_write_enable_a       = 1'b0;
    main_x_enable_a             = 1'b0;
    main_x_address_a            = '0;
    main_x_in_a                 = '0;
    main_x_write_enable_b       = 1'b0;
    main_x_enable_b             = 1'b0;
    main_x_address_b            = '0;
    main_x_in_b                 = '0;

    main_A_a0_a0_write_enable_a = 1'b0;
    main_A_a0_a0_enable_a       = 1'b0;
    main_A_a0_a0_address_a      = '0;
    main_A_a0_a0_in_a           = '0;
    main_A_a0_a0_write_enable_b = 1'b0;
    main_A_a0_a0_enable_b       = 1'b0;
    main_A_a0_a0_address_b      = '0;
    main_A_a0_a0_in_b           = '0;

    case (state_reg)
      S_CLR: begin
        main_y_write_enable_a = 1'b1;
        main_y_enable_a       = 1'b1;
        main_y_address_a      = j_reg;
      end

      S_DOT_RD: begin
        main_A_a0_a0_enable_a  = 1'b1;
        main_A_a0_a0_address_a = a_addr;
        main_x_enable_a        = 1'b1;
        main_x_address_a       = j_reg;
      end

      S_UPD_RD: begin
        main_A_a0_a0_enable_a  = 1'b1;
        main_A_a0_a0_address_a = a_addr;
        main_y_enable_a        = 1'b1;
        main_y_address_a       = j_reg;
      end

      S_UPD_WR: begin
        // Port a is idle here and the next read targets j+1, so the write
        // never collides with a read of the same word.
        main_y_write_enable_b = 1'b1;
        main_y_enable_b       = 1'b1;
        main_y_address_b      = j_reg;
        main_y_in_b           = mac_y;
      end

      default: begin
      end
    endcase
  end

  assign main_y_byteena_a       = {BW{1'b1}};
  assign main_y_byteena_b       = {BW{1'b1}};
  assign main_x_byteena_a       = {BW{1'b1}};
  assign main_x_byteena_b       = {BW{1'b1}};
  assign main_A_a0_a0_byteena_a = {BW{1'b1}};
  assign main_A_a0_a0_byteena_b = {BW{1'b1}};

endmodule

// File: tb/tb_kernel_atax.sv
// -----------------------------------------------------------------------------
// tb_kernel_atax
// Directed bench for kernel_atax (N=8, DATA_W=32) with behavioural dual-port
// RAMs for A, x and y. Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_kernel_atax;

  localparam int N = 8;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic finish;

  logic        y_we_a, y_en_a, y_we_b, y_en_b;
  logic [2:0]  y_addr_a, y_addr_b;
  logic [31:0] y_in_a, y_in_b, y_out_a, y_out_b;
  logic [3:0]  y_be_a, y_be_b;
  logic        x_we_a, x_en_a, x_we_b, x_en_b;
  logic [2:0]  x_addr_a, x_addr_b;
  logic [31:0] x_in_a, x_in_b, x_out_a, x_out_b;
  logic [3:0]  x_be_a, x_be_b;
  logic        a_we_a, a_en_a, a_we_b, a_en_b;
  logic [5:0]  a_addr_a, a_addr_b;
  logic [31:0] a_in_a, a_in_b, a_out_a, a_out_b;
  logic [3:0]  a_be_a, a_be_b;

  logic [31:0] a_mem [N*N];
  logic [31:0] x_mem [N];
  logic [31:0] y_mem [N];

  logic        preset_y = 1'b0;
  logic [31:0] preset_val = '0;
  int          bad_writes = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kernel_atax #(.N(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .main_y_write_enable_a(y_we_a), .main_y_enable_a(y_en_a),
    .main_y_address_a(y_addr_a), .main_y_in_a(y_in_a),
    .main_y_byteena_a(y_be_a), .main_y_out_a(y_out_a),
    .main_y_write_enable_b(y_we_b), .main_y_enable_b(y_en_b),
    .main_y_address_b(y_addr_b), .main_y_in_b(y_in_b),
    .main_y_byteena_b(y_be_b), .main_y_out_b(y_out_b),
    .main_x_write_enable_a(x_we_a), .main_x_enable_a(x_en_a),
    .main_x_address_a(x_addr_a), .main_x_in_a(x_in_a),
    .main_x_byteena_a(x_be_a), .main_x_out_a(x_out_a),
    .main_x_write_enable_b(x_we_b), .main_x_enable_b(x_en_b),
    .main_x_address_b(x_addr_b), .main_x_in_b(x_in_b),
    .main_x_byteena_b(x_be_b), .main_x_out_b(x_out_b),
    .main_A_a0_a0_write_enable_a(a_we_a), .main_A_a0_a0_enable_a(a_en_a),
    .main_A_a0_a0_address_a(a_addr_a), .main_A_a0_a0_in_a(a_in_a),
    .main_A_a0_a0_byteena_a(a_be_a), .main_A_a0_a0_out_a(a_out_a),
    .main_A_a0_a0_write_enable_b(a_we_b), .main_A_a0_a0_enable_b(a_en_b),
    .main_A_a0_a0_address_b(a_addr_b), .main_A_a0_a0_in_b(a_in_b),
    .main_A_a0_a0_byteena_b(a_be_b), .main_A_a0_a0_out_b(a_out_b)
  );

  // RAM models: registered read, write on the same edge. A and x are
  // read-only here; any write attempt is counted as an error.
  always @(posedge clk) begin
    if (preset_y) begin
      for (int k = 0; k < N; k++) y_mem[k] <= preset_val;
    end else begin
      if (y_en_a) begin
        y_out_a <= y_mem[y_addr_a];
        if (y_we_a) y_mem[y_addr_a] <= y_in_a;
      end
      if (y_en_b) begin
        y_out_b <= y_mem[y_addr_b];
        if (y_we_b) y_mem[y_addr_b] <= y_in_b;
      end
    end
    if (x_en_a) x_out_a <= x_mem[x_addr_a];
    if (x_en_b) x_out_b <= x_mem[x_addr_b];
    if (a_en_a) a_out_a <= a_mem[a_addr_a];
    if (a_en_b) a_out_b <= a_mem[a_addr_b];
    if (x_we_a || x_we_b || a_we_a || a_we_b) bad_writes <= bad_writes + 1;
  end

  logic [11:0] strobes;
  assign strobes = {y_we_a, y_en_a, y_we_b, y_en_b, x_we_a, x_en_a,
                    x_we_b, x_en_b, a_we_a, a_en_a, a_we_b, a_en_b};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input int kind);
    // kind 0: A=I, x=1..8   1: all ones   2: single -3*5
    // kind 3: 0x10000 wrap  4: A=I, x=8..1
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (kind)
          0, 4:    a_mem[i*N+j] = (i == j) ? 32'd1 : 32'd0;
          1:       a_mem[i*N+j] = 32'd1;
          2:       a_mem[i*N+j] = (i == 0 && j == 0) ? 32'hFFFF_FFFD : 32'd0;
          default: a_mem[i*N+j] = (i == 0 && j == 0) ? 32'h0001_0000 : 32'd0;
        endcase
      end
      case (kind)
        0:       x_mem[i] = 32'(i + 1);
        1:       x_mem[i] = 32'd1;
        2:       x_mem[i] = (i == 0) ? 32'd5 : 32'd0;
        3:       x_mem[i] = (i == 0) ? 32'h0001_0000 : 32'd0;
        default: x_mem[i] = 32'(N - i);
      endcase
    end
  endtask

  task automatic preset(input logic [31:0] v);
    @(negedge clk);
    preset_val = v;
    preset_y   = 1'b1;
    @(negedge clk);
    preset_y   = 1'b0;
  endtask

  // Counts edges until finish is seen at a negedge; optionally re-pulses
  // start for one cycle at pulse_at. Returns -1 if the bound expires.
  task automatic wait_finish(input int pulse_at, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (finish) begin
        cyc = c;
        break;
      end
      if (pulse_at > 0 && c == pulse_at) start = 1'b1;
      else if (pulse_at > 0 && c == pulse_at + 1) start = 1'b0;
    end
  endtask

  task automatic do_run(input string name, input int pulse_at, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);        // edge 0
    @(negedge clk);
    start = 1'b0;
    wait_finish(pulse_at, lat);
    $display("run %s: finish after %0d cycles", name, lat);
    check({name, "_latency"}, lat, 32'd265);
    @(negedge clk);
    check({name, "_finish_width"}, {31'd0, finish}, 32'd0);
  endtask

  task automatic check_y(input string name, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [31:0] rest,
                         input bit ramp_up, input bit ramp_down);
    logic [31:0] exp;
    for (int k = 0; k < N; k++) begin
      if (ramp_up)        exp = 32'(k + 1);
      else if (ramp_down) exp = 32'(N - k);
      else if (k == 0)    exp = e0;
      else if (k == 1)    exp = e1;
      else                exp = rest;
      check($sformatf("%s_y%0d", name, k), y_mem[k], exp);
    end
  endtask

  initial begin
    int lat;
    int gap;
    int late_events;
    reset = 1'b1;
    start = 1'b0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("rst_strobes", {20'd0, strobes}, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    check("rst_addr", {8'd0, y_addr_a, y_addr_b, x_addr_a, x_addr_b,
                       a_addr_a, a_addr_b}, 32'd0);
    check("rst_data", y_in_a | y_in_b | x_in_a | x_in_b | a_in_a | a_in_b,
          32'd0);
    check("rst_byteena", {8'd0, y_be_a, y_be_b, x_be_a, x_be_b, a_be_a, a_be_b},
          32'h00FF_FFFF);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_quiet", {19'd0, finish, strobes}, 32'd0);
    end

    // Identity
    set_inputs(0);
    preset(32'hDEAD_BEEF);
    do_run("identity", 0, lat);
    check_y("identity", 0, 0, 0, 1'b1, 1'b0);

    // All ones, stale y contents must be cleared first
    set_inputs(1);
    preset(32'h1234_5678);
    do_run("ones", 0, lat);
    check_y("ones", 32'd64, 32'd64, 32'd64, 1'b0, 1'b0);

    // Signed: tmp = -15, y[0] = -3 * -15 = 45
    set_inputs(2);
    preset(32'hFFFF_FFFF);
    do_run("signed", 0, lat);
    check_y("signed", 32'd45, 32'd0, 32'd0, 1'b0, 1'b0);

    // Wrap: 0x10000 * 0x10000 = 2^32 -> 0
    set_inputs(3);
    preset(32'h5555_5555);
    do_run("wrap", 0, lat);
    check_y("wrap", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // start re-pulsed mid-run is ignored
    set_inputs(0);
    do_run("repulse", 50, lat);
    check_y("repulse", 0, 0, 0, 1'b1, 1'b0);

    // start held high: back-to-back runs every 266 cycles
    set_inputs(1);
    preset(32'hAAAA_AAAA);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_finish(0, lat);
    check("held_first", lat, 32'd265);
    wait_finish(0, gap);
    start = 1'b0;
    $display("run held: first %0d cycles, period %0d cycles", lat, gap);
    check("held_period", gap, 32'd266);
    @(negedge clk);
    check("held_stop", {19'd0, finish, strobes}, 32'd0);
    check_y("held", 32'd64, 32'd64, 32'd64, 1'b0, 1'b0);

    // Reset mid-run at cycle 100
    set_inputs(1);
    preset(32'h0000_0000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (100) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_strobes", {19'd0, finish, strobes}, 32'd0);
    reset = 1'b0;
    late_events = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (finish || y_we_a || y_we_b) late_events++;
    end
    $display("run midreset: %0d events after reset", late_events);
    check("midrst_silent", late_events, 32'd0);

    // Fresh run after reset: A=I, x=8..1
    set_inputs(4);
    do_run("fresh", 0, lat);
    check_y("fresh", 0, 0, 0, 1'b0, 1'b1);

    check("xa_writes", bad_writes, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
